// File: rtl/mult_25x18.sv
// Signed 25x18 multiplier stage: radix-4 Booth partial products, carry-save
// reduction, final carry-propagate add, optional M register on the product.
module mult_25x18 #(
  parameter int data_width_in1 = 25,
  parameter int data_width_in2 = 18,
  parameter bit MREG           = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     ce,
  input  logic [data_width_in1-1:0]                in1,
  input  logic [data_width_in2-1:0]                in2,
  output logic [data_width_in1+data_width_in2-1:0] out
);

  localparam int W1  = data_width_in1;
  localparam int W2  = data_width_in2;
  localparam int WO  = W1 + W2;
  localparam int NPP = (W2 + 1) / 2;
  localparam int BW  = 2 * NPP;

  logic [BW:0]     b_ext;
  logic [WO-1:0]   a_ext;
  logic [WO-1:0]   a_dbl;
  logic [NPP-1:0]  neg;
  logic [WO-1:0]   corr_row;
  logic [WO-1:0]   ops       [NPP+1];
  logic [WO-1:0]   sum_vec   [1:NPP];
  logic [WO-1:0]   carry_vec [1:NPP];
  logic [WO-1:0]   prod_next;

  // Multiplier padded to an even width with its sign bit, plus the implicit
  // zero below bit 0 that the first Booth triplet looks at.
  generate
    if (BW > W2) begin : g_b_pad
      assign b_ext = {in2[W2-1], in2, 1'b0};
    end else begin : g_b_even
      assign b_ext = {in2, 1'b0};
    end
  endgenerate

  assign a_ext = {{(WO-W1){in1[W1-1]}}, in1};
  assign a_dbl = {a_ext[WO-2:0], 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < NPP; gi++) begin : g_pp
      logic [2:0]    trip;
      logic          sel_one;
      logic          sel_two;
      logic [WO-1:0] mag;

      assign trip    = b_ext[2*gi+2 : 2*gi];
      assign sel_one = trip[1] ^ trip[0];
      assign sel_two = (trip == 3'b011) || (trip == 3'b100);
      // Triplet 111 is digit zero, so it must not contribute a negation.
      assign neg[gi] = trip[2] & ~(trip[1] & trip[0]);
      assign mag     = sel_one ? a_ext : (sel_two ? a_dbl : '0);
      assign ops[gi] = (neg[gi] ? ~mag : mag) << (2*gi);
    end
  endgenerate

  // The +1 of each negated partial product lands at bit 2*i; those bits never
  // overlap, so they pack into one extra operand row.
  always_comb begin
    corr_row = '0;
    for (int i = 0; i < NPP; i++) begin
      corr_row[2*i] = neg[i];
    end
  end

  assign ops[NPP] = corr_row;

  assign sum_vec[1]   = ops[0];
  assign carry_vec[1] = ops[1];

  generate
    for (gi = 2; gi <= NPP; gi++) begin : g_csa
      logic [WO-1:0] maj;

      assign maj            = (sum_vec[gi-1] & carry_vec[gi-1]) |
                              (sum_vec[gi-1] & ops[gi]) |
                              (carry_vec[gi-1] & ops[gi]);
      assign sum_vec[gi]    = sum_vec[gi-1] ^ carry_vec[gi-1] ^ ops[gi];
      assign carry_vec[gi]  = {maj[WO-2:0], 1'b0};
    end
  endgenerate

  assign prod_next = sum_vec[NPP] + carry_vec[NPP];

  generate
    if (MREG) begin : g_mreg
      logic [WO-1:0] prod_reg = '0;

      always_ff @(posedge clk) begin
        if (rst) begin
          prod_reg <= '0;
        end else if (ce) begin
          prod_reg <= prod_next;
        end
      end

      assign out = prod_reg;
    end else begin : g_comb
      assign out = prod_next;
    end
  endgenerate

endmodule

// File: tb/tb_mult_25x18.sv
// Directed and random checks of mult_25x18, registered and combinational builds
// side by side, against hand values and a signed-multiply reference.
module tb_mult_25x18;

  localparam int W1 = 25;
  localparam int W2 = 18;
  localparam int WO = W1 + W2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce  = 1'b0;
  logic [W1-1:0] in1 = '0;
  logic [W2-1:0] in2 = '0;
  logic [WO-1:0] out_reg;
  logic [WO-1:0] out_comb;

  int errors = 0;
  int checks = 0;

  mult_25x18 #(.data_width_in1(W1), .data_width_in2(W2), .MREG(1'b1)) dut_reg (
    .clk(clk), .rst(rst), .ce(ce), .in1(in1), .in2(in2), .out(out_reg)
  );

  mult_25x18 #(.data_width_in1(W1), .data_width_in2(W2), .MREG(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .ce(ce), .in1(in1), .in2(in2), .out(out_comb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WO-1:0] got, input logic [WO-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
               tag, $signed(got), got, $signed(exp), exp);
    end else begin
      $display("ok   %s: %0d", tag, $signed(got));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [W1-1:0] a, input logic signed [W2-1:0] b);
    in1 = a;
    in2 = b;
  endtask

  function automatic logic [WO-1:0] ref_mul(input logic [W1-1:0] a, input logic [W2-1:0] b);
    logic signed [WO-1:0] sa, sb;
    sa = $signed({{(WO-W1){a[W1-1]}}, a});
    sb = $signed({{(WO-W2){b[W2-1]}}, b});
    return sa * sb;
  endfunction

  // Directed table: operands and hand-computed products.
  typedef struct {
    string             tag;
    logic signed [24:0] a;
    logic signed [17:0] b;
    logic signed [42:0] p;
  } vec_t;

  vec_t vecs [6];
  vec_t pipe [4];

  initial begin
    vecs[0] = '{"zero",       25'sd0,         18'sd0,       43'sd0};
    vecs[1] = '{"identity",   25'sd12345,     18'sd1,       43'sd12345};
    vecs[2] = '{"neg_one_sq", -25'sd1,        -18'sd1,      43'sd1};
    vecs[3] = '{"min_min",    -25'sd16777216, -18'sd131072, 43'sd2199023255552};
    vecs[4] = '{"max_max",    25'sd16777215,  18'sd131071,  43'sd2199006347265};
    vecs[5] = '{"min_max",    -25'sd16777216, 18'sd131071,  -43'sd2199006478336};

    pipe[0] = '{"pipe0", 25'sd3,     18'sd5,      43'sd15};
    pipe[1] = '{"pipe1", -25'sd4,    18'sd6,      -43'sd24};
    pipe[2] = '{"pipe2", 25'sd1000,  -18'sd1000,  -43'sd1000000};
    pipe[3] = '{"pipe3", -25'sd2,    -18'sd2,     43'sd4};

    // Power-up value before any reset.
    #1;
    check("powerup", out_reg, '0);

    drive(25'sd55, 18'sd66);
    rst = 1'b1;
    ce  = 1'b1;
    tick();
    check("reset", out_reg, '0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b);
      #1;
      check({vecs[i].tag, "_comb"}, out_comb, vecs[i].p);
      tick();
      check({vecs[i].tag, "_reg"}, out_reg, vecs[i].p);
    end

    // Clock-enable and reset control.
    drive(25'sd100, -18'sd3);
    tick();
    check("load", out_reg, -43'sd300);
    ce = 1'b0;
    drive(25'sd7, 18'sd7);
    tick();
    check("hold1", out_reg, -43'sd300);
    tick();
    check("hold2", out_reg, -43'sd300);
    ce = 1'b1;
    tick();
    check("resume", out_reg, 43'sd49);
    rst = 1'b1;
    tick();
    check("mid_reset", out_reg, '0);
    rst = 1'b0;
    #1;
    check("reset_gap", out_reg, '0);
    tick();
    check("release", out_reg, 43'sd49);
    rst = 1'b1;
    ce  = 1'b0;
    tick();
    check("rst_over_ce", out_reg, '0);
    rst = 1'b0;
    ce  = 1'b1;

    // Back-to-back operands: each product one edge after its operands.
    foreach (pipe[i]) begin
      drive(pipe[i].a, pipe[i].b);
      tick();
      check(pipe[i].tag, out_reg, pipe[i].p);
    end

    // Random regression on both builds.
    begin
      logic [WO-1:0] exp_prev;
      logic [WO-1:0] exp_now;
      exp_prev = 43'sd4;
      for (int n = 0; n < 640; n++) begin
        logic [31:0] ra;
        logic [31:0] rb;
        ra = $urandom;
        rb = $urandom;
        case (n % 16)
          0: ra[24:0] = 25'h1000000;
          1: rb[17:0] = 18'h20000;
          2: ra[24:0] = 25'h0FFFFFF;
          3: rb[17:0] = 18'h1FFFF;
          default: ;
        endcase
        check("rnd_reg_prev", out_reg, exp_prev);
        in1 = ra[24:0];
        in2 = rb[17:0];
        exp_now = ref_mul(in1, in2);
        #1;
        check("rnd_comb", out_comb, exp_now);
        tick();
        exp_prev = exp_now;
      end
      check("rnd_reg_last", out_reg, exp_prev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_25x18.md
Name: mult_25x18

Overview:
- Signed two's-complement 25x18 multiplier: the multiplier stage of the DSP48E1-style slice.
- Takes the A-path operand (25 bit) and the B-path operand (18 bit) and produces the full-precision 43-bit product.
- Feeds the downstream ALU/accumulator stage.
- Optional output pipeline register (M register) with clock enable, analogous to MREG/CEM.

Parameters:
- data_width_in1, 25, width of operand in1 (A path).
- data_width_in2, 18, width of operand in2 (B path).
- MREG, 1, 0 = purely combinational output; 1 = one registered stage on the product.

Ports:
- clk  input  1  single clock; rising edge active.
- rst  input  1  synchronous, active-high reset of the M register.
- ce  input  1  clock enable of the M register (CEM equivalent).
- in1  input  data_width_in1  multiplicand, signed two's complement.
- in2  input  data_width_in2  multiplier, signed two's complement.
- out  output  data_width_in1+data_width_in2 (43)  signed product.

Behaviour:
- Arithmetic
  - out = signed(in1) * signed(in2), both operands sign-extended to the full output width.
  - No truncation, rounding or saturation.
  - 43 bits holds every result, including (-2^24)*(-2^17) = +2^41; overflow is impossible.
- Implementation
  - Radix-4 modified Booth recoding of in2: 9 partial products, each sign-extended to 43 bits.
  - Reduced by an adder tree (Wallace/CSA or plain adder chain acceptable), then a final carry-propagate add.
  - Result must be bit-exact to the signed product for all 2^43 input combinations.
  - No vendor primitives or "*" operator required; "*" may be used only in the verification model.
- MREG=0
  - out is combinational from in1/in2 and settles within the same cycle.
  - clk, rst and ce are ignored.
- MREG=1
  - Product registered on the rising clk edge; latency is exactly 1 cycle: inputs valid before edge N appear on out after edge N.
  - rst=1 at an edge: out = 0. rst has priority over ce.
  - rst=0, ce=1: out loads the current product.
  - rst=0, ce=0: out holds its previous value.
  - Power-up / pre-reset value of out is 0 (register initialised to 0).
  - Reset mid-stream clears only the register. The first edge after rst deasserts (with ce=1) loads the current product; nothing is flushed or replayed.
- Inputs are treated as stable data; there is no handshake. Every enabled edge is a new sample.
- Any X on in1/in2 may propagate to out; no X-masking is required.

Test Plan:
- Zero and identity (MREG=1, ce=1, rst released)
  - in1=0, in2=0 -> out=0 after 1 edge.
  - in1=12345, in2=1 -> out=12345.
  - in1=-1 (0x1FFFFFF), in2=-1 (0x3FFFF) -> out=+1.
- Corners
  - in1=-16777216, in2=-131072 -> out=+2199023255552 (0x20000000000).
  - in1=16777215, in2=131071 -> out=2199006347265.
  - in1=-16777216, in2=131071 -> out=-2199006478336.
- Control
  - Load in1=100, in2=-3 -> out=-300.
  - Drop ce, change inputs to 7, 7 -> out stays -300.
  - Raise ce -> out=49 next edge.
  - Assert rst with ce=1 -> out=0 at the next edge.
  - Release rst -> current product appears one edge later.
- Pipelining
  - Back-to-back new operands every cycle -> out shows each product exactly one cycle after its operands; no bubbles or duplicates.
- Random regression
  - 600+ random operand pairs at 10-unit spacing, both MREG=0 and MREG=1.
  - Compare against the signed-multiply reference model, delayed by the configured latency.
  - Zero mismatches.
